// File: rtl/cosim_mmio_arbiter_pkg.sv
// MMIO event bundle shared by the device taps, FIFOs and the cosim channel.
package MMIOStruct;

    typedef struct packed {
        logic        store;
        logic [2:0]  len;
        logic [31:0] val;
        logic [31:0] addr;
    } MMIOPack;

    typedef struct packed {
        logic [2:0]  len;
        logic [31:0] val;
        logic [31:0] addr;
    } MMIOData;

    localparam int MMIO_NSRC = 4;

    typedef logic [1:0] MMIOSrcIdx;

    function automatic MMIOData mmio_strip(input MMIOPack p);
        return '{len: p.len, val: p.val, addr: p.addr};
    endfunction

endpackage

// File: rtl/cosim_mmio_arbiter_fifo.sv
// Per-source event FIFO: circular buffer with occupancy counter.
module cosim_mmio_fifo
    import MMIOStruct::*;
#(
    parameter int DEPTH = 4
) (
    input  logic    clk,
    input  logic    rst,
    input  logic    i_push,
    input  logic    i_pop,
    input  MMIOData i_data,
    output MMIOData o_data,
    output logic    o_full,
    output logic    o_empty
);

    localparam int AW = $clog2(DEPTH);

    MMIOData        r_mem [DEPTH];
    logic [AW-1:0]  r_wptr;
    logic [AW-1:0]  r_rptr;
    logic [AW:0]    r_count;

    assign o_data  = r_mem[r_rptr];
    assign o_full  = (r_count == (AW+1)'(DEPTH));
    assign o_empty = (r_count == '0);

    // Storage carries no reset; occupancy alone decides validity.
    always_ff @(posedge clk) begin
        if (i_push) begin
            r_mem[r_wptr] <= i_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (i_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (i_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/cosim_mmio_arbiter.sv
// Serialises device MMIO stores onto the cosim channel via per-source
// FIFOs and a round-robin grant into a registered valid/ready slot.
module cosim_mmio_arbiter
    import MMIOStruct::*;
#(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  MMIOPack    timer_mmio,
    input  MMIOPack    disp_mmio,
    input  MMIOPack    uart_mmio,
    input  MMIOPack    mmuer_mmio,
    input  logic       cosim_ready,
    output MMIOPack    cosim_mmio,
    output logic [3:0] overflow,
    output logic       busy
);

    MMIOPack   w_src   [MMIO_NSRC];
    MMIOData   w_head  [MMIO_NSRC];
    logic [3:0] w_full;
    logic [3:0] w_empty;
    logic [3:0] w_req;
    logic [3:0] w_push;
    logic [3:0] w_pop;
    logic       w_free;
    logic       w_take;
    MMIOSrcIdx  w_grant;
    MMIOSrcIdx  w_idx;

    MMIOPack    r_out;
    MMIOSrcIdx  r_rr_ptr;
    logic [3:0] r_overflow;

    assign w_src[0] = timer_mmio;
    assign w_src[1] = disp_mmio;
    assign w_src[2] = uart_mmio;
    assign w_src[3] = mmuer_mmio;

    assign w_req  = ~w_empty;
    assign w_free = !r_out.store || cosim_ready;
    assign w_take = w_free && (|w_req);

    // Scan from the farthest offset down so the nearest requester wins.
    always_comb begin
        w_grant = r_rr_ptr;
        w_idx   = r_rr_ptr;
        for (int k = MMIO_NSRC - 1; k >= 0; k--) begin
            w_idx = r_rr_ptr + MMIOSrcIdx'(k);
            if (w_req[w_idx]) begin
                w_grant = w_idx;
            end
        end
    end

    for (genvar i = 0; i < MMIO_NSRC; i++) begin : g_src
        assign w_pop[i]  = w_take && (w_grant == MMIOSrcIdx'(i));
        assign w_push[i] = w_src[i].store && (!w_full[i] || w_pop[i]);

        cosim_mmio_fifo #(
            .DEPTH (DEPTH)
        ) u_fifo (
            .clk     (clk),
            .rst     (rst),
            .i_push  (w_push[i]),
            .i_pop   (w_pop[i]),
            .i_data  (mmio_strip(w_src[i])),
            .o_data  (w_head[i]),
            .o_full  (w_full[i]),
            .o_empty (w_empty[i])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out      <= '0;
            r_rr_ptr   <= '0;
            r_overflow <= '0;
        end else begin
            if (w_take) begin
                r_out.store <= 1'b1;
                r_out.len   <= w_head[w_grant].len;
                r_out.val   <= w_head[w_grant].val;
                r_out.addr  <= w_head[w_grant].addr;
                r_rr_ptr    <= w_grant + 1'b1;
            end else if (w_free) begin
                r_out.store <= 1'b0;
            end
            for (int i = 0; i < MMIO_NSRC; i++) begin
                if (w_src[i].store && !w_push[i]) begin
                    r_overflow[i] <= 1'b1;
                end
            end
        end
    end

    assign cosim_mmio = r_out;
    assign overflow   = r_overflow;
    assign busy       = (|w_req) || r_out.store;

endmodule

// File: tb/tb_cosim_mmio_arbiter.sv
// Directed checks of cosim_mmio_arbiter against hand-computed results.
module tb_cosim_mmio_arbiter;
    import MMIOStruct::*;

    logic       clk = 1'b0;
    logic       rst;
    MMIOPack    timer_mmio;
    MMIOPack    disp_mmio;
    MMIOPack    uart_mmio;
    MMIOPack    mmuer_mmio;
    logic       cosim_ready;
    MMIOPack    cosim_mmio;
    logic [3:0] overflow;
    logic       busy;

    int n_chk = 0;
    int n_err = 0;
    logic [31:0] q [$];

    cosim_mmio_arbiter #(
        .DEPTH (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .timer_mmio  (timer_mmio),
        .disp_mmio   (disp_mmio),
        .uart_mmio   (uart_mmio),
        .mmuer_mmio  (mmuer_mmio),
        .cosim_ready (cosim_ready),
        .cosim_mmio  (cosim_mmio),
        .overflow    (overflow),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag,
                         input logic [63:0] got,
                         input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic MMIOPack ev(input logic [31:0] a,
                                   input logic [31:0] v,
                                   input logic [2:0]  l);
        return '{store: 1'b1, len: l, val: v, addr: a};
    endfunction

    // Hold ready high, logging every accepted value until idle.
    task automatic drain(input int budget);
        cosim_ready = 1'b1;
        for (int c = 0; c < budget; c++) begin
            if (!busy) break;
            if (cosim_mmio.store) q.push_back(cosim_mmio.val);
            tick();
        end
        check("drain_idle", busy, 1'b0);
    endtask

    initial begin
        rst         = 1'b1;
        timer_mmio  = '0;
        disp_mmio   = '0;
        uart_mmio   = '0;
        mmuer_mmio  = '0;
        cosim_ready = 1'b1;
        #12;
        check("rst_out", cosim_mmio, '0);
        check("rst_busy", busy, 1'b0);
        check("rst_ovf", overflow, 4'b0);
        check("rst_ptr", dut.r_rr_ptr, 2'd0);
        rst = 1'b0;
        tick();

        // All four sources at once.
        timer_mmio = ev(32'h10, 32'd0, 3'd4);
        disp_mmio  = ev(32'h20, 32'd1, 3'd4);
        uart_mmio  = ev(32'h30, 32'd2, 3'd4);
        mmuer_mmio = ev(32'h40, 32'd3, 3'd4);
        tick();
        timer_mmio = '0;
        disp_mmio  = '0;
        uart_mmio  = '0;
        mmuer_mmio = '0;
        check("sim_lat", cosim_mmio.store, 1'b0);
        for (int k = 0; k < 4; k++) begin
            tick();
            check("sim_vld", cosim_mmio.store, 1'b1);
            check("sim_val", cosim_mmio.val, 32'(k));
        end
        check("sim_ptr", dut.r_rr_ptr, 2'd0);
        tick();
        check("sim_end", cosim_mmio.store, 1'b0);

        // Single UART event: two-cycle latency, one-cycle pulse.
        uart_mmio = ev(32'h1000_0000, 32'h41, 3'd1);
        tick();
        uart_mmio = '0;
        check("one_lat", cosim_mmio.store, 1'b0);
        check("one_busy", busy, 1'b1);
        tick();
        check("one_vld", cosim_mmio.store, 1'b1);
        check("one_addr", cosim_mmio.addr, 32'h1000_0000);
        check("one_val", cosim_mmio.val, 32'h41);
        check("one_len", cosim_mmio.len, 3'd1);
        tick();
        check("one_off", cosim_mmio.store, 1'b0);
        check("one_idle", busy, 1'b0);

        // Backpressure with three timer events.
        cosim_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            timer_mmio = ev(32'h200, 32'hA0 + 32'(k), 3'd4);
            tick();
        end
        timer_mmio = '0;
        for (int k = 0; k < 3; k++) begin
            check("bp_vld", cosim_mmio.store, 1'b1);
            check("bp_hold", cosim_mmio.val, 32'hA0);
            tick();
        end
        q.delete();
        drain(20);
        check("bp_cnt", q.size(), 3);
        for (int k = 0; k < 3 && k < q.size(); k++)
            check("bp_ord", q[k], 32'hA0 + 32'(k));

        // Overflow on the display FIFO.
        cosim_ready = 1'b0;
        for (int k = 0; k < 6; k++) begin
            disp_mmio = ev(32'h300, 32'h10 + 32'(k), 3'd2);
            tick();
        end
        disp_mmio = '0;
        check("ovf_flag", overflow, 4'b0010);
        q.delete();
        drain(20);
        check("ovf_cnt", q.size(), 5);
        for (int k = 0; k < 5 && k < q.size(); k++)
            check("ovf_ord", q[k], 32'h10 + 32'(k));
        check("ovf_stk", overflow, 4'b0010);

        // Fairness: timer floods, UART must get through quickly.
        begin
            int xfers;
            int seen;
            cosim_ready = 1'b1;
            xfers = 0;
            seen  = 0;
            for (int c = 0; c < 12; c++) begin
                timer_mmio = ev(32'h400, 32'd100 + 32'(c), 3'd4);
                uart_mmio  = (c == 3) ? ev(32'h500, 32'h55, 3'd1) : '0;
                tick();
                if (c >= 3 && seen == 0 && cosim_mmio.store) begin
                    xfers++;
                    if (cosim_mmio.val == 32'h55) seen = xfers;
                end
            end
            timer_mmio = '0;
            uart_mmio  = '0;
            check("fair_seen", seen != 0, 1'b1);
            check("fair_win", seen <= 2, 1'b1);
            q.delete();
            drain(40);
        end

        // Reset while events are queued and the slot is full.
        cosim_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            timer_mmio = ev(32'h600, 32'hC0 + 32'(k), 3'd4);
            disp_mmio  = ev(32'h700, 32'hD0 + 32'(k), 3'd4);
            tick();
        end
        timer_mmio = '0;
        disp_mmio  = '0;
        check("mr_pre", cosim_mmio.store, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        check("mr_vld", cosim_mmio.store, 1'b0);
        check("mr_busy", busy, 1'b0);
        check("mr_ovf", overflow, 4'b0);
        check("mr_addr", cosim_mmio.addr, 32'h0);
        tick();
        rst = 1'b0;
        cosim_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("mr_stale", cosim_mmio.store, 1'b0);
            check("mr_idle", busy, 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
